// File: rtl/transmissor_relatorio_pkg.sv
// Shared constants, FSM encoding and parity helper for the serial status reporter.
package transmissor_relatorio_pkg;

    localparam int TAM_RELATORIO = 4;
    localparam int BITS_QUADRO   = 11;

    localparam logic [6:0] CHAR_ABERTA  = 7'h41;
    localparam logic [6:0] CHAR_FECHADA = 7'h46;
    localparam logic [6:0] CHAR_FIM     = 7'h23;

    typedef enum logic [3:0] {
        ST_INICIAL   = 4'd0,
        ST_PREPARADO = 4'd1,
        ST_TRANSMITE = 4'd2,
        ST_ESPERA    = 4'd3,
        ST_PROXIMO   = 4'd4,
        ST_FINAL     = 4'd5
    } estado_t;

    function automatic logic paridade_par(input logic [6:0] dados);
        return ^dados;
    endfunction

endpackage

// File: rtl/transmissor_relatorio_if.sv
// Status/handshake bundle between the reporter and its surroundings.
interface transmissor_relatorio_if;
    logic       enviar;
    logic       comportaAberta;
    logic [7:0] peso;
    logic       saida_serial;
    logic       ocupado;
    logic       pronto;
    logic [3:0] db_estado;

    modport master (
        output enviar, comportaAberta, peso,
        input  saida_serial, ocupado, pronto, db_estado
    );

    modport slave (
        input  enviar, comportaAberta, peso,
        output saida_serial, ocupado, pronto, db_estado
    );
endinterface

// File: rtl/transmissor_relatorio_tx_serial_7E2.sv
// Single-character 7E2 transmitter: start, 7 data bits LSB first, even parity, 2 stops.
module tx_serial_7E2
    import transmissor_relatorio_pkg::*;
#(
    parameter int CLOCKS_POR_BIT = 5208
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       partida,
    input  logic [6:0] dados_ascii,
    output logic       saida_serial,
    output logic       pronto
);

    localparam int TW = (CLOCKS_POR_BIT > 2) ? $clog2(CLOCKS_POR_BIT) : 1;
    localparam logic [TW-1:0] TICK_ULTIMO = TW'(CLOCKS_POR_BIT - 1);
    localparam logic [TW-1:0] TICK_PENULT = TW'(CLOCKS_POR_BIT - 2);
    localparam logic [3:0]    BIT_ULTIMO  = 4'(BITS_QUADRO - 1);

    logic [TW-1:0] tick_q, tick_d;
    logic [3:0]    bit_q, bit_d;
    logic [10:0]   shift_q, shift_d;
    logic          ativo_q, ativo_d;
    logic          fim_bit_s;
    logic          fim_quadro_s;

    // Bit timing, frame loading and shifting; line is shift_q[0], refilled with ones.
    always_comb begin
        tick_d       = tick_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        ativo_d      = ativo_q;
        fim_bit_s    = (tick_q == TICK_ULTIMO);
        fim_quadro_s = ativo_q && fim_bit_s && (bit_q == BIT_ULTIMO);
        // Done is flagged one cycle early so the parent can chain the next frame gap-free.
        pronto       = ativo_q && (bit_q == BIT_ULTIMO) && (tick_q == TICK_PENULT);
        if (partida && (!ativo_q || fim_quadro_s)) begin
            shift_d = {2'b11, paridade_par(dados_ascii), dados_ascii, 1'b0};
            tick_d  = {TW{1'b0}};
            bit_d   = 4'd0;
            ativo_d = 1'b1;
        end else if (ativo_q) begin
            if (fim_bit_s) begin
                tick_d  = {TW{1'b0}};
                shift_d = {1'b1, shift_q[10:1]};
                if (bit_q == BIT_ULTIMO) begin
                    ativo_d = 1'b0;
                    bit_d   = 4'd0;
                end else begin
                    bit_d = bit_q + 4'd1;
                end
            end else begin
                tick_d = tick_q + TW'(1);
            end
        end else begin
            shift_d = {11{1'b1}};
        end
    end

    // State registers; reset forces the line high at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick_q  <= {TW{1'b0}};
            bit_q   <= 4'd0;
            shift_q <= {11{1'b1}};
            ativo_q <= 1'b0;
        end else begin
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            ativo_q <= ativo_d;
        end
    end

    assign saida_serial = shift_q[0];

endmodule

// File: rtl/transmissor_relatorio.sv
// Serial status reporter: sends gate state, weight in hex and '#' as four 7E2 characters.
module transmissor_relatorio
    import transmissor_relatorio_pkg::*;
#(
    parameter int CLOCKS_POR_BIT = 5208
) (
    input  logic                    clock,
    input  logic                    reset,
    transmissor_relatorio_if.slave  bus
);

    localparam logic [1:0] IDX_ULTIMO = 2'(TAM_RELATORIO - 1);

    estado_t    estado_q, estado_d;
    logic [1:0] idx_q, idx_d;
    logic       aberta_q, aberta_d;
    logic [7:0] peso_q, peso_d;
    logic       ocupado_q, ocupado_d;
    logic       pronto_q, pronto_d;
    logic       partida_s;
    logic [6:0] char_s;
    logic       tx_pronto_s;
    logic       tx_saida_s;

    function automatic logic [6:0] nibble_ascii(input logic [3:0] nib);
        logic [6:0] r;
        if (nib < 4'd10) begin
            r = 7'h30 + {3'b000, nib};
        end else begin
            r = 7'h37 + {3'b000, nib};
        end
        return r;
    endfunction

    // Report sequencing; status inputs are captured only when a request is accepted.
    always_comb begin
        estado_d = estado_q;
        idx_d    = idx_q;
        aberta_d = aberta_q;
        peso_d   = peso_q;
        case (estado_q)
            ST_INICIAL: begin
                if (bus.enviar) begin
                    aberta_d = bus.comportaAberta;
                    peso_d   = bus.peso;
                    estado_d = ST_PREPARADO;
                end else begin
                    estado_d = ST_INICIAL;
                end
            end
            ST_PREPARADO: begin
                idx_d    = 2'd0;
                estado_d = ST_TRANSMITE;
            end
            ST_TRANSMITE: estado_d = ST_ESPERA;
            ST_ESPERA: begin
                if (tx_pronto_s) begin
                    estado_d = ST_PROXIMO;
                end else begin
                    estado_d = ST_ESPERA;
                end
            end
            ST_PROXIMO: begin
                if (idx_q == IDX_ULTIMO) begin
                    estado_d = ST_FINAL;
                end else begin
                    idx_d    = idx_q + 2'd1;
                    estado_d = ST_TRANSMITE;
                end
            end
            ST_FINAL: estado_d = ST_INICIAL;
            default: begin
                idx_d    = 2'd0;
                estado_d = ST_INICIAL;
            end
        endcase
        // The character is launched on the edge that enters transmite.
        partida_s = (estado_d == ST_TRANSMITE);
        ocupado_d = (estado_d != ST_INICIAL) && (estado_d != ST_FINAL);
        pronto_d  = (estado_d == ST_FINAL);
    end

    // Character selection follows the index being loaded, not the current one.
    always_comb begin
        case (idx_d)
            2'd0:    char_s = aberta_q ? CHAR_ABERTA : CHAR_FECHADA;
            2'd1:    char_s = nibble_ascii(peso_q[7:4]);
            2'd2:    char_s = nibble_ascii(peso_q[3:0]);
            default: char_s = CHAR_FIM;
        endcase
    end

    // FSM and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q  <= ST_INICIAL;
            idx_q     <= 2'd0;
            aberta_q  <= 1'b0;
            peso_q    <= 8'h00;
            ocupado_q <= 1'b0;
            pronto_q  <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            idx_q     <= idx_d;
            aberta_q  <= aberta_d;
            peso_q    <= peso_d;
            ocupado_q <= ocupado_d;
            pronto_q  <= pronto_d;
        end
    end

    tx_serial_7E2 #(
        .CLOCKS_POR_BIT (CLOCKS_POR_BIT)
    ) u_tx (
        .clock        (clock),
        .reset        (reset),
        .partida      (partida_s),
        .dados_ascii  (char_s),
        .saida_serial (tx_saida_s),
        .pronto       (tx_pronto_s)
    );

    assign bus.saida_serial = tx_saida_s;
    assign bus.ocupado      = ocupado_q;
    assign bus.pronto       = pronto_q;
    assign bus.db_estado    = estado_q;

endmodule

// File: doc/transmissor_relatorio.md
# transmissor_relatorio

Serial status reporter: on command, sends a 4-character ASCII report over a 7E2 serial line. The report carries gate state and the 8-bit weight in hex. It is the transmit end of the same link whose receiver decodes the gate commands. It sits beside the gate/servo controller, sampling its status, and drives the outgoing serial pin toward the host.

## Interface
Parameters:
- CLOCKS_POR_BIT, 5208, clock cycles per serial bit (50 MHz / 9600 baud); must be ≥ 2

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- enviar  in  1  request one report; sampled only in state inicial
- comportaAberta  in  1  gate state; 1 = open
- peso  in  8  weight value to report
- saida_serial  out  1  serial line; idles high
- ocupado  out  1  high from the cycle after acceptance until the report ends
- pronto  out  1  one-cycle pulse after the last stop bit of the last character
- db_estado  out  4  current report FSM state code, for debug

## Operation
- Report is 4 characters, in this order:
  - 'A' (0x41) if comportaAberta = 1, 'F' (0x46) if 0
  - ASCII hex of peso[7:4]
  - ASCII hex of peso[3:0]
  - '#' (0x23)
- Hex digits are uppercase:
  - 0–9 map to 0x30–0x39
  - A–F map to 0x41–0x46
- comportaAberta and peso are latched in the cycle enviar is accepted. Later changes do not alter a report in flight.
- Character frame is 11 bits, sent in this order:
  - start bit (0)
  - data[0]..data[6], LSB first
  - even parity bit, equal to the XOR of data[6:0]
  - 2 stop bits (1)
- Report FSM states and transitions:
  - inicial → preparado, on enviar = 1
  - preparado: load character index 0 → transmite
  - transmite: pulse partida to the char sub-module → espera
  - espera: wait for the char pronto → proximo
  - proximo: if index = 3 → final; else increment index → transmite
  - final: assert pronto for one cycle → inicial
- enviar while ocupado = 1 is ignored. It is neither queued nor allowed to restart the report.
- enviar held high continuously starts a new report every time the FSM re-enters inicial.
- Reset values:
  - saida_serial = 1
  - ocupado = 0
  - pronto = 0
  - db_estado = inicial (0)
  - character index = 0
- Reset is asynchronous and may arrive mid-frame. saida_serial returns high immediately, the report is abandoned, and no pronto is issued.

## Timing
- Acceptance: enviar is high at edge N. The FSM is in preparado after N, and ocupado = 1 from N+1.
- Start bit of character 0 appears on saida_serial within 3 cycles of acceptance. Each later character's start bit follows the previous character's last stop bit within 3 cycles.
- Every bit, including each stop bit, is held for exactly CLOCKS_POR_BIT cycles.
- saida_serial is driven from a register, so it never glitches.
- pronto:
  - rises in the cycle after the final stop bit of '#' completes
  - is high for exactly 1 cycle
  - ocupado falls in the same cycle pronto rises
- Total report duration is 44·CLOCKS_POR_BIT plus at most 12 cycles of FSM overhead.

## Structure
- Shared package holds:
  - character constants CHAR_ABERTA, CHAR_FECHADA, CHAR_FIM
  - the report length (4)
  - the FSM state encodings
- Sub-module tx_serial_7E2 is the single-character transmitter:
  - ports: clock, reset, partida, dados_ascii[6:0], saida_serial, pronto
  - contains a bit-period counter, a bit counter (0..10) and an 11-bit shift register
  - the parent module instantiates it once
- Nibble-to-ASCII conversion is a local function in the parent.

## Test plan
All scenarios use CLOCKS_POR_BIT = 4.
- Scenario 1, basic report:
  - stimulus: comportaAberta = 1, peso = 0x3C, pulse enviar
  - required: the line decodes to 0x41 (parity 0), 0x33 (parity 0), 0x43 (parity 1), 0x23 (parity 1)
  - required: each bit lasts 4 cycles, and a single pronto pulse follows
- Scenario 2, gate closed and boundary digits:
  - stimulus: comportaAberta = 0, peso = 0xF0
  - required: characters 'F' (0x46, parity 1), 'F' (0x46), '0' (0x30, parity 0), '#'
- Scenario 3, latching:
  - stimulus: change peso to 0x00 and comportaAberta to 0 mid-report; pulse enviar during character 2
  - required: the original report completes unchanged, no second report starts, and exactly one pronto is seen
- Scenario 4, reset mid-operation:
  - stimulus: assert reset during the parity bit of character 1
  - required: saida_serial = 1 immediately, ocupado = 0, no pronto
  - required: after reset releases, a new enviar yields a full, correct report
- Scenario 5, back-to-back:
  - stimulus: hold enviar high with peso = 0x09
  - required: consecutive reports "A09#", each separated by at most 3 idle-high cycles, with one pronto per report
